symbol_count: RTL
=================

Name: symbol_count

Overview:
- Upstream stage of the Huffman sorter.
- Accepts a stream of gray-level symbols and builds an occurrence histogram for symbols 1..6 over a fixed-length frame.
- When the frame is complete, presents CNT1..CNT6 and pulses CNT_valid for one cycle. The sorter loads on that pulse.
- Holds the counts and refuses new samples until the controller releases the frame with frame_clr.

Parameters:
- NUM_SAMPLES, 100, symbols per frame (1..255).
- DATA_W, 8, width of gray_data.
- CNT_W, 8, width of each histogram count; must match the sorter's CNT ports.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- gray_valid  input  1  gray_data is valid this cycle
- gray_data  input  DATA_W  symbol value; legal values are 1..6
- gray_ready  output  1  block can accept a sample this cycle
- frame_clr  input  1  releases held counts and starts a new frame
- CNT1..CNT6  output  CNT_W each  occurrence count of symbols 1..6
- CNT_valid  output  1  one-cycle pulse: CNT1..CNT6 final for this frame
- err_sym  output  1  sticky: the frame contained a value outside 1..6

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE
  - CNT1..CNT6=0, sample counter=0
  - CNT_valid=0, err_sym=0, gray_ready=1
- Accept: a sample is accepted at a rising edge where gray_valid && gray_ready.
- States:
  - IDLE: gray_ready=1. First accepted sample is counted and moves state to COUNT. With NUM_SAMPLES=1 it moves straight to DONE.
  - COUNT: gray_ready=1. Each accepted sample:
    - increments the sample counter;
    - if gray_data is in 1..6, increments CNT[gray_data];
    - otherwise sets err_sym and leaves all CNTs unchanged. The sample still counts toward NUM_SAMPLES.
    - The edge accepting sample NUM_SAMPLES moves state to DONE.
  - DONE: exactly one cycle. CNT_valid=1, gray_ready=0, CNTs include every sample of the frame. Always moves to HOLD.
  - HOLD: CNT_valid=0, gray_ready=0, CNTs and err_sym stable. frame_clr=1 moves state to IDLE; at that same edge CNT1..CNT6, the sample counter and err_sym clear to 0.
- Timing:
  - CNT updates take effect at the accepting edge (1-cycle latency, sample to count).
  - CNT_valid is high in the cycle immediately after the edge that accepts the last sample.
- Arithmetic:
  - Counts saturate at 2^CNT_W-1 and never wrap. Only reachable if NUM_SAMPLES exceeds that value.
  - The sample counter is wide enough for NUM_SAMPLES and is compared for equality.
  - Sum of CNT1..CNT6 equals NUM_SAMPLES minus the number of illegal samples.
- Boundary rules:
  - gray_valid while gray_ready=0: ignored, no state change. The source must hold or drop the sample.
  - frame_clr in IDLE, COUNT or DONE: ignored.
  - frame_clr and gray_valid in the same HOLD cycle: frame_clr wins, the sample is not accepted. gray_ready rises the next cycle.
  - gray_valid gaps during COUNT: the counter simply waits; there is no timeout.
  - Reset mid-frame: all partial counts are lost, outputs return to reset values, CNT_valid is never emitted for that frame.
  - CNT_valid is registered, never combinational from inputs.

Decomposition:
- Shared package huffman_pkg:
  - NUM_SYM=6, CNT_W=8 (shared with the sorter)
  - state enum {IDLE, COUNT, DONE, HOLD}
  - symbol legality function: 1 <= v <= NUM_SYM
- One sub-module, sat_counter: CNT_W-wide counter with inc and clr inputs and saturation. Instantiated six times, one per symbol.
- FSM, sample counter and err_sym live in the top module.

Test Plan:
- Reset value check: reset=0 asynchronously mid-cycle -> all CNT=0, CNT_valid=0, err_sym=0, gray_ready=1 immediately.
- Basic frame:
  - NUM_SAMPLES=6, stream 1,2,3,4,5,6 back-to-back -> CNT_valid pulses once, 1 cycle after the 6th accept, all CNT=1, err_sym=0.
  - gray_ready=0 afterward until frame_clr.
- Skewed histogram with gaps:
  - NUM_SAMPLES=100, samples 40×1, 25×2, 15×3, 10×4, 6×5, 4×6 with random gray_valid gaps.
  - Expected: CNT1..CNT6=40,25,15,10,6,4, single CNT_valid pulse.
- Illegal symbols: NUM_SAMPLES=4, stream 0,7,3,3 -> CNT3=2, others 0, err_sym=1, CNT_valid after the 4th sample.
- Hold and release:
  - In HOLD, drive gray_valid=1 with data 1 for 10 cycles -> CNTs unchanged.
  - Assert frame_clr with gray_valid=1 -> sample not accepted, next cycle all CNT=0, gray_ready=1.
  - New frame then counts correctly.
- Reset mid-frame: after 50 of 100 samples, pulse reset=0 -> counts zero, no CNT_valid. A following full frame of 100×5 gives CNT5=100.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman front end (symbol counter and sorter).
package huffman_pkg;

    localparam int unsigned NUM_SYM = 6;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // A symbol is countable when it lies in 1..NUM_SYM.
    function automatic logic sym_legal(input int unsigned v);
        return (v >= 1) && (v <= NUM_SYM);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, one per histogram bin.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    // Clear has priority; increment stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/symbol_count.sv
// Frame histogram of symbols 1..6 feeding the Huffman sorter.
module symbol_count #(
    parameter int unsigned NUM_SAMPLES = 100,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_valid,
    input  logic [DATA_W-1:0] gray_data,
    output logic              gray_ready,
    input  logic              frame_clr,
    output logic [CNT_W-1:0]  CNT1,
    output logic [CNT_W-1:0]  CNT2,
    output logic [CNT_W-1:0]  CNT3,
    output logic [CNT_W-1:0]  CNT4,
    output logic [CNT_W-1:0]  CNT5,
    output logic [CNT_W-1:0]  CNT6,
    output logic              CNT_valid,
    output logic              err_sym
);

    import huffman_pkg::*;

    localparam int unsigned        SCNT_W   = $clog2(NUM_SAMPLES + 1);
    localparam logic [SCNT_W-1:0]  LAST_IDX = SCNT_W'(NUM_SAMPLES - 1);

    state_t              state;
    state_t              state_next;
    logic                ready_next;
    logic                valid_next;
    logic                accept;
    logic                last;
    logic                clr;
    logic                legal;
    logic [SCNT_W-1:0]   sample_cnt;
    logic [NUM_SYM-1:0]  inc;
    logic [CNT_W-1:0]    cnt [NUM_SYM];

    assign accept = gray_valid && gray_ready;
    assign last   = accept && (sample_cnt == LAST_IDX);
    assign clr    = (state == HOLD) && frame_clr;
    assign legal  = sym_legal(32'(gray_data));

    // One saturating bin per legal symbol value.
    for (genvar i = 0; i < NUM_SYM; i++) begin : g_bin
        assign inc[i] = accept && (gray_data == DATA_W'(i + 1));

        sat_counter #(.W(CNT_W)) u_bin (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[i]),
            .clr   (clr),
            .cnt   (cnt[i])
        );
    end

    assign CNT1 = cnt[0];
    assign CNT2 = cnt[1];
    assign CNT3 = cnt[2];
    assign CNT4 = cnt[3];
    assign CNT5 = cnt[4];
    assign CNT6 = cnt[5];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: count until the last sample, pulse DONE, hold until released.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, COUNT: begin
                if (accept) begin
                    state_next = last ? DONE : COUNT;
                end
            end
            DONE:    state_next = HOLD;
            HOLD:    if (frame_clr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state so ready/valid come straight from flops.
    always_comb begin
        ready_next = 1'b0;
        valid_next = 1'b0;
        if ((state_next == IDLE) || (state_next == COUNT)) begin
            ready_next = 1'b1;
        end
        if (state_next == DONE) begin
            valid_next = 1'b1;
        end
    end

    // Output registers for the handshake and frame-complete pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray_ready <= 1'b1;
            CNT_valid  <= 1'b0;
        end else begin
            gray_ready <= ready_next;
            CNT_valid  <= valid_next;
        end
    end

    // Sample counter and sticky illegal-symbol flag, both cleared on frame release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            err_sym    <= 1'b0;
        end else if (clr) begin
            sample_cnt <= '0;
            err_sym    <= 1'b0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + SCNT_W'(1);
            if (!legal) begin
                err_sym <= 1'b1;
            end
        end
    end

endmodule
